// File: rtl/path_pulse_pkg.sv
// Shared constants, types and small helpers for the path pulse filter.
// Every delay, limit and window counter in the design is CNT_W bits wide.
package path_pulse_pkg;

   // Width of delay values, pending ages and window down-counters.
   localparam int CNT_W = 4;

   // Selects where the showcancelled error window begins.
   typedef enum logic {
      EVT_ON_EVENT  = 1'b0,
      EVT_ON_DETECT = 1'b1
   } win_mode_e;

   // Counts upward but holds at all-ones, so an age can never wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Counts downward but holds at zero.
   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   // Smaller of two counter values.
   function automatic logic [CNT_W-1:0] cnt_min(input logic [CNT_W-1:0] x,
                                                input logic [CNT_W-1:0] y);
      return (x < y) ? x : y;
   endfunction

   // Larger of two counter values.
   function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] x,
                                                input logic [CNT_W-1:0] y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/pulse_err_window.sv
// Error window tracker for cancelled pulses.
// start_in/end_in are offsets in clock edges from the edge where open is
// high: err is registered high at edges start..end-1. The window is held as
// a pair of down-counters; a window opened while another is still running
// merges with it (earliest start, latest end).
module pulse_err_window
   import path_pulse_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             open,
   input  logic [CNT_W-1:0] start_in,
   input  logic [CNT_W-1:0] end_in,
   output logic             err
);

   logic             win_v_q,     win_v_d;
   logic [CNT_W-1:0] win_start_q, win_start_d;
   logic [CNT_W-1:0] win_end_q,   win_end_d;
   logic             err_q,       err_d;

   logic             cur_v;
   logic [CNT_W-1:0] cur_start;
   logic [CNT_W-1:0] cur_end;

   // Merge a newly opened window into the live one, then age both counters.
   always_comb begin
      cur_v       = win_v_q;
      cur_start   = win_start_q;
      cur_end     = win_end_q;
      win_v_d     = 1'b0;
      win_start_d = '0;
      win_end_d   = '0;
      err_d       = 1'b0;

      if (open) begin
         cur_v = 1'b1;
         if (win_v_q) begin
            cur_start = cnt_min(win_start_q, start_in);
            cur_end   = cnt_max(win_end_q, end_in);
         end else begin
            cur_start = start_in;
            cur_end   = end_in;
         end
      end

      if (cur_v) begin
         err_d       = (cur_start == '0) && (cur_end != '0);
         win_start_d = sat_dec(cur_start);
         win_end_d   = sat_dec(cur_end);
         win_v_d     = (cur_end > CNT_W'(1));
      end
   end

   // Window counters and registered err.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_v_q     <= 1'b0;
         win_start_q <= '0;
         win_end_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         win_v_q     <= win_v_d;
         win_start_q <= win_start_d;
         win_end_q   <= win_end_d;
         err_q       <= err_d;
      end
   end

   assign err = err_q;

endmodule

// File: rtl/path_pulse_filter.sv
// Clocked inertial path delay with IEEE 1364 style pulse control.
// One pending transition is tracked at a time. An input edge that returns
// to the committed output before the pending edge matures cancels it; the
// cancellation is either silent (narrower than REJECT) or, with
// SHOW_CANCELLED, opens an err window while the output would be X.
module path_pulse_filter
   import path_pulse_pkg::*;
#(
   parameter int RISE_DLY       = 2,
   parameter int FALL_DLY       = 3,
   parameter int REJECT         = 0,
   parameter int SHOW_CANCELLED = 0,
   parameter int ON_DETECT      = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic out,
   output logic err,
   output logic cancel
);

   localparam logic [CNT_W-1:0] RISE_C   = CNT_W'(RISE_DLY);
   localparam logic [CNT_W-1:0] FALL_C   = CNT_W'(FALL_DLY);
   localparam win_mode_e        WIN_MODE = (ON_DETECT != 0) ? EVT_ON_DETECT : EVT_ON_EVENT;

   // Delay that applies to a transition towards val.
   function automatic logic [CNT_W-1:0] dly_of(input logic val);
      return val ? RISE_C : FALL_C;
   endfunction

   logic             out_q,      out_d;
   logic             target_q,   target_d;
   logic             pend_v_q,   pend_v_d;
   logic             pend_val_q, pend_val_d;
   logic [CNT_W-1:0] pend_age_q, pend_age_d;
   logic             cancel_q,   cancel_d;

   logic             commit;
   logic             is_edge;
   logic             do_cancel;
   logic             show_err;
   logic [CNT_W-1:0] pend_dly;
   logic [CNT_W-1:0] lead_rel;
   logic [CNT_W-1:0] trail_rel;

   logic             win_open;
   logic [CNT_W-1:0] win_start;
   logic [CNT_W-1:0] win_end;

   // Scheduling: commit a matured edge first, then judge the sampled input.
   always_comb begin
      out_d      = out_q;
      target_d   = target_q;
      pend_v_d   = pend_v_q;
      pend_val_d = pend_val_q;
      pend_age_d = pend_age_q;
      cancel_d   = 1'b0;
      do_cancel  = 1'b0;
      show_err   = 1'b0;

      pend_dly = dly_of(pend_val_q);
      commit   = pend_v_q && (pend_age_q >= pend_dly);
      is_edge  = (a != target_q);

      if (commit) begin
         out_d      = pend_val_q;
         pend_v_d   = 1'b0;
         pend_age_d = '0;
      end else if (pend_v_q) begin
         pend_age_d = sat_inc(pend_age_q);
      end

      if (is_edge) begin
         if (!pend_v_q || commit) begin
            // Fresh schedule; a same-cycle commit has already landed.
            target_d   = a;
            pend_v_d   = 1'b1;
            pend_val_d = a;
            pend_age_d = CNT_W'(1);
         end else begin
            // Input is back at the committed output: drop the pending edge.
            do_cancel  = 1'b1;
            target_d   = out_q;
            pend_v_d   = 1'b0;
            pend_age_d = '0;
            cancel_d   = 1'b1;
            show_err   = (SHOW_CANCELLED != 0) && (int'(pend_age_q) >= REJECT);
         end
      end
   end

   // Error window bounds, as edge offsets from the cancelling edge.
   always_comb begin
      win_open  = 1'b0;
      win_start = '0;
      win_end   = '0;
      lead_rel  = pend_dly - pend_age_q;
      trail_rel = dly_of(a);

      if (do_cancel && show_err) begin
         win_open = 1'b1;
         if (WIN_MODE == EVT_ON_DETECT) begin
            win_start = '0;
            win_end   = cnt_max(lead_rel, trail_rel);
         end else if (lead_rel == trail_rel) begin
            win_start = lead_rel;
            win_end   = lead_rel + 1'b1;
         end else begin
            win_start = cnt_min(lead_rel, trail_rel);
            win_end   = cnt_max(lead_rel, trail_rel);
         end
      end
   end

   // Output, target, pending slot and cancel strobe registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q      <= 1'b0;
         target_q   <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_val_q <= 1'b0;
         pend_age_q <= '0;
         cancel_q   <= 1'b0;
      end else begin
         out_q      <= out_d;
         target_q   <= target_d;
         pend_v_q   <= pend_v_d;
         pend_val_q <= pend_val_d;
         pend_age_q <= pend_age_d;
         cancel_q   <= cancel_d;
      end
   end

   pulse_err_window u_win (
      .clk      (clk),
      .rst      (rst),
      .open     (win_open),
      .start_in (win_start),
      .end_in   (win_end),
      .err      (err)
   );

   assign out    = out_q;
   assign cancel = cancel_q;

endmodule

// File: doc/path_pulse_filter.md
# path_pulse_filter

Clocked inertial path-delay element with pulse filtering. It drives `out` from input `a` with separate rise and fall delays, counted in clock cycles. When a scheduled transition is cancelled by a later input edge, the block either drops the pulse silently or reports it on `err`, following IEEE 1364 reject and error limits and the showcancelled on-event and on-detect styles. It sits on the output side of a modelled path and is the synthesizable counterpart of a specify-block path declaration, used as a golden reference for pulse-control checks.

## Interface
- `RISE_DLY`, default 2: cycles from a sampled 0→1 edge of `a` to `out`=1. Legal range 1..15.
- `FALL_DLY`, default 3: cycles from a sampled 1→0 edge to `out`=0. Legal range 1..15.
- `REJECT`, default 0: a cancelled pulse of width w < `REJECT` is filtered silently. Legal range 0..min(`RISE_DLY`,`FALL_DLY`). The error limit is always equal to the pending edge's delay.
- `SHOW_CANCELLED`, default 0:
  - 0: error-range pulses are filtered and `err` never asserts.
  - 1: error-range pulses assert `err`.
- `ON_DETECT`, default 0: selects the `err` window start.
  - 0: on-event.
  - 1: on-detect.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a` in 1: path input, sampled every cycle.
- `out` out 1: delayed, filtered path output.
- `err` out 1: high while the output would be X in simulation (showcancelled window).
- `cancel` out 1: one-cycle strobe on every cancellation, whether rejected or error.

## Operation
- State:
  - `target`: the last scheduled value; equals `out` when nothing is pending.
  - One pending slot: `pend_v`, `pend_val`, `pend_age`.
  - Error window: `win_v`, `win_start`, `win_end`, held as down-counters.
- Edge at cycle t: `a` ≠ `target`.
  - With no pending transition: schedule `out`←`a` at t+D, where D = `RISE_DLY` if `a`=1, else `FALL_DLY`. Set `target`←`a`.
  - With a pending transition of age w, where 1 ≤ w < D_pend: `a` has returned to the current `out` value, so the pending transition is cancelled. Set `target`←`out` and pulse `cancel` at t.
    - w < `REJECT`: the cancellation is silent.
    - Otherwise, if `SHOW_CANCELLED`=1, open an error window:
      - lead = t − w + D_pend, the time the cancelled edge would have taken effect.
      - trail = t + D_new, the time the cancelling edge would have taken effect.
      - On-event: `err` is high over [min(lead,trail), max(lead,trail)), at least one cycle.
      - On-detect: `err` is high over [t, max(lead,trail)).
- Pending age reaches D: `out`←`pend_val` and the slot clears.
- Simultaneous events: an edge sampled in the same cycle that `out` updates is treated as a fresh schedule with no pending slot. The update takes effect first.
- Overlapping windows: a new error window opened while one is active merges. The start stays at the earlier value and the end becomes the later one.
- `out` is never forced by `err`. During a window `out` keeps its last committed value.

## Timing
- Reset (`rst`=1 at an edge): `out`=0, `err`=0, `cancel`=0, `target`=0, pending slot and window cleared.
  - Assertion mid-operation discards all scheduled transitions and windows.
  - The first edge after reset is judged against `target`=0.
- Latency:
  - A sampled `a` edge at the clock edge of cycle t makes `out` change after the edge of cycle t+D.
  - `cancel` is registered and high in cycle t+1 for a detection at t, for one cycle.
  - The `err` window is registered the same way: "high over [s,e)" means `err` is high in cycles s+1..e.
- Counter widths are 4 bits. There is no wrap-around: ages saturate at D.

## Structure
- A shared package `path_pulse_pkg` holds:
  - The delay/limit width constant (4).
  - The enum for window mode (`EVT_ON_EVENT`, `EVT_ON_DETECT`).
- One sub-module, `pulse_err_window`: the start/end down-counter pair with merge logic. It takes open/start/end and produces `err`.
- The top level holds scheduling, the pending slot and the reject/error decision.

## Test plan
- Defaults, rising edge on `a` at t0, held → `out` rises after cycle t0+2. Falling edge at t0+10 → `out` falls after t0+13. `err` and `cancel` stay 0 throughout.
- `REJECT`=2, `SHOW_CANCELLED`=1, `out`=1; `a` falls at t0 and rises at t0+1 (w=1) → `cancel` high in cycle t0+2, `out` stays 1, `err` stays 0.
- Same setup, `a` falls at t0 and rises at t0+2 (w=2) → lead=t0+3, trail=t0+4. On-event: `err` is high in cycle t0+4 only. `out` stays 1.
- `RISE_DLY`=4, `FALL_DLY`=2, `SHOW_CANCELLED`=1; `a` rises at t0 and falls at t0+1 (negative pulse: lead=t0+4, trail=t0+3).
  - On-event: `err` is high in cycle t0+4.
  - On-detect: `err` is high in cycles t0+2..t0+4.
- `SHOW_CANCELLED`=0, same stimulus as the previous scenario → `cancel` strobes, `err` stays 0, `out` stays 0.
- Rising edge at t0 (defaults), then `rst` pulsed at t0+1 → `out` stays 0 and no transition occurs at t0+2. `a` still high after reset → re-scheduled from t0+2, `out` rises after t0+4.
